bitmanip_crypto_pipe: RTL
=========================

// Module: bitmanip_crypto_pipe
// PURPOSE
//   Pipelined scalar bit-manipulation / crypto-permutation unit (Zbkb/Zbkx class) for the integer EX path.
//   Generalises the bitutils word functions to XLEN 32/64, with arbitrary rotate amounts and PACK ops.
//   Adds a valid/ready handshake, 1..2 register stages, flush and a pass-through tag.
//   Sits beside the ALU and is issued by the dispatch stage. Results retire to the writeback arbiter.
// PARAMETERS
//   XLEN    32  datapath width; legal values are 32 and 64 only (elaboration $error otherwise)
//   STAGES  2   register stages from accept to result; legal values are 1 and 2
//   TAG_W   5   width of the opaque tag (rd index); tag is carried unchanged to the output
// PORTS
//   clk        in   1      clock; all state updates on posedge
//   rst_n      in   1      synchronous reset, active low
//   flush_i    in   1      drop all in-flight ops (pipeline kill)
//   in_valid_i in   1      op request valid
//   in_ready_o out  1      unit can accept this cycle
//   op_i       in   4      operation code (see BEHAVIOUR)
//   rs1_i      in   XLEN   operand 1 (data / lookup table)
//   rs2_i      in   XLEN   operand 2 (shamt / indices / high half)
//   tag_i      in   TAG_W  destination tag
//   out_valid_o out 1      result valid
//   out_ready_i in  1      consumer takes result this cycle
//   result_o   out  XLEN   result
//   tag_o      out  TAG_W  tag of result
//   illegal_o  out  1      op not supported at this XLEN (result_o = 0)
// BEHAVIOUR
//   Ops: 0 ROL, 1 ROR, 2 BREV8, 3 REV8, 4 ZIP, 5 UNZIP, 6 XPERM8, 7 XPERM4, 8 PACK, 9 PACKH; 10-15 illegal.
//   ROL/ROR: shamt = rs2[$clog2(XLEN)-1:0]. A shamt of 0 returns rs1.
//   BREV8: reverse the bit order inside each byte. REV8: reverse the byte order of the full XLEN word.
//   ZIP/UNZIP: XLEN=32 only. ZIP out[2i]=in[i], out[2i+1]=in[i+16]; UNZIP is its inverse.
//     At XLEN=64 these ops are illegal.
//   XPERM8: for each byte k, idx = rs2 byte k; out byte k = rs1 byte idx if idx < XLEN/8, else 0.
//   XPERM4: the same rule on nibbles, with limit XLEN/4.
//   PACK = {rs2[XLEN/2-1:0], rs1[XLEN/2-1:0]}. PACKH = zero-extended {rs2[7:0], rs1[7:0]}.
//   Illegal ops: result_o=0 and illegal_o=1. An illegal op still occupies a slot and still handshakes.
//   Handshake:
//     - An op is accepted when in_valid_i && in_ready_o && !flush_i.
//     - A result is taken when out_valid_o && out_ready_i.
//     - in_ready_o = !full_pipe || out_ready_i, where full_pipe = every stage holds a valid op.
//     - Each stage advances when its successor is empty or advancing; otherwise it holds.
//     - No bubbles are inserted when out_ready_i stays high.
//   Latency: with no stall, out_valid_o is asserted STAGES cycles after the accept edge.
//     Throughput is 1 op/cycle. Ops complete in order.
//   Stage split when STAGES=2:
//     - S1 registers op, rs1, rs2, tag and a decoded one-hot op select.
//     - S2 computes the result and registers result, tag and illegal.
//   Stage split when STAGES=1: compute and register in a single stage.
//   Output stability: while out_valid_o && !out_ready_i, result_o, tag_o and illegal_o hold stable.
//   flush_i:
//     - Clears all stage valid bits on the next edge.
//     - Takes priority over a same-cycle accept and over a same-cycle output take.
//     - in_ready_o stays combinationally valid during flush, but the accept is masked.
//   Reset: rst_n low clears all valid bits and drives result_o, tag_o and illegal_o to 0 on the next edge.
//     Reset mid-operation discards in-flight ops.
//     in_ready_o is 1 in the first cycle after reset.
//   Datapath registers other than the valid bits need not be reset; outputs are gated to 0 while !out_valid_o.
// TESTING
//   1. XLEN=32: ROL rs1=0x12345678, rs2=8 -> 0x34567812 after 2 cycles.
//      ROR with the same operands -> 0x78123456. Shamt 0 -> rs1.
//   2. BREV8 rs1=0x01020380 -> 0x80403C01? No: -> 0x8040C001. REV8 rs1=0x11223344 -> 0x44332211.
//   3. ZIP 0x0000FFFF -> 0x55555555. UNZIP 0x55555555 -> 0x0000FFFF.
//      XLEN=64 ZIP -> illegal_o=1, result 0.
//   4. XPERM8 rs1=0x44332211, rs2=0x00010305 -> 0x11224400.
//      XPERM4 rs1=0x76543210, rs2=0xF0000001 -> 0x00000001.
//   5. Backpressure: hold out_ready_i=0 and stream 4 ops. in_ready_o drops after STAGES accepts.
//      Release out_ready_i: all ops emerge in order with correct tags, with no loss or duplication.
//   6. flush_i high together with in_valid_i while 2 ops are in flight -> out_valid_o=0 next cycle, nothing accepted.
//      rst_n low mid-stream -> all outputs 0 and in_ready_o=1 after the reset edge.
```

Test 2 contains a struck-out wrong value that must be removed before check-in. Corrected line: `//   2. BREV8 rs1=0x01020380 -> 0x8040C001. REV8 rs1=0x11223344 -> 0x44332211.`

Source files
------------

// File: rtl/bitmanip_crypto_pipe_if.sv
// Request/result bus between the dispatch stage, the bit-manipulation unit
// and the writeback arbiter. The unit sits on the slave side; the issuing
// logic (or a testbench) sits on the master side. XLEN and TAG_W must match
// the parameters of the unit the interface is connected to.
interface bitmanip_crypto_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);

  logic             in_valid_i;
  logic             in_ready_o;
  logic [3:0]       op_i;
  logic [XLEN-1:0]  rs1_i;
  logic [XLEN-1:0]  rs2_i;
  logic [TAG_W-1:0] tag_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [XLEN-1:0]  result_o;
  logic [TAG_W-1:0] tag_o;
  logic             illegal_o;

  modport master (
    output in_valid_i, op_i, rs1_i, rs2_i, tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, tag_o, illegal_o
  );

  modport slave (
    input  in_valid_i, op_i, rs1_i, rs2_i, tag_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, tag_o, illegal_o
  );

endinterface

// File: rtl/bitmanip_crypto_pipe.sv
// Pipelined scalar bit-manipulation / crypto-permutation unit for the integer
// EX path: rotates, byte/bit reversal, zip/unzip, crossbar permutes and packs.
// One or two register stages with a valid/ready handshake on both ends, an
// in-order pipeline that never inserts bubbles, a pipeline kill (flush_i) and
// an opaque tag carried alongside each op. Only the valid bits are reset; the
// result bus is forced to zero whenever no valid result is presented.
module bitmanip_crypto_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  bitmanip_crypto_pipe_if.slave  bus
);

  localparam int SHW    = $clog2(XLEN);
  localparam int NBYTE  = XLEN / 8;
  localparam int NNIB   = XLEN / 4;
  localparam int NOPS   = 10;
  localparam bit ZIP_OK = (XLEN == 32);

  typedef enum logic [3:0] {
    OP_ROL    = 4'd0,
    OP_ROR    = 4'd1,
    OP_BREV8  = 4'd2,
    OP_REV8   = 4'd3,
    OP_ZIP    = 4'd4,
    OP_UNZIP  = 4'd5,
    OP_XPERM8 = 4'd6,
    OP_XPERM4 = 4'd7,
    OP_PACK   = 4'd8,
    OP_PACKH  = 4'd9
  } opCode_e;

  if ((XLEN != 32) && (XLEN != 64)) begin : gBadXlen
    $error("bitmanip_crypto_pipe: XLEN must be 32 or 64");
  end

  if ((STAGES != 1) && (STAGES != 2)) begin : gBadStages
    $error("bitmanip_crypto_pipe: STAGES must be 1 or 2");
  end

  // One-hot op select. ZIP/UNZIP get no select bit at XLEN=64 so that an
  // illegal op always decodes to an all-zero select and a zero result.
  function automatic logic [NOPS-1:0] decodeOp(input logic [3:0] op);
    logic [NOPS-1:0] sel;
    for (int i = 0; i < NOPS; i++) begin
      sel[i] = (op == 4'(i)) && (ZIP_OK || ((i != 4) && (i != 5)));
    end
    return sel;
  endfunction

  function automatic logic isIllegal(input logic [3:0] op);
    return (op > 4'd9) || (!ZIP_OK && ((op == OP_ZIP) || (op == OP_UNZIP)));
  endfunction

  // All op results are computed in parallel and merged by an AND-OR mux on
  // the one-hot select, keeping the result path a single flat level.
  function automatic logic [XLEN-1:0] computeOp(
    input logic [NOPS-1:0] sel,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b
  );
    logic [2*XLEN-1:0] dbl;
    logic [SHW-1:0]    sh;
    logic [XLEN-1:0]   rol, ror, brev, rev, zip, unzip, xp8, xp4, pk, pkh;
    logic [7:0]        idx8;
    logic [3:0]        idx4;

    sh  = b[SHW-1:0];
    dbl = {a, a} << sh;
    rol = dbl[2*XLEN-1:XLEN];
    dbl = {a, a} >> sh;
    ror = dbl[XLEN-1:0];

    for (int k = 0; k < NBYTE; k++) begin
      for (int j = 0; j < 8; j++) begin
        brev[8*k + j] = a[8*k + 7 - j];
      end
      rev[8*k +: 8] = a[8*(NBYTE-1-k) +: 8];
    end

    zip   = '0;
    unzip = '0;
    for (int i = 0; i < 16; i++) begin
      zip[2*i]       = a[i];
      zip[2*i + 1]   = a[i + 16];
      unzip[i]       = a[2*i];
      unzip[i + 16]  = a[2*i + 1];
    end

    for (int k = 0; k < NBYTE; k++) begin
      idx8 = b[8*k +: 8];
      xp8[8*k +: 8] = (idx8 < 8'(NBYTE)) ? 8'(a >> {idx8, 3'b000}) : 8'h00;
    end

    for (int k = 0; k < NNIB; k++) begin
      idx4 = b[4*k +: 4];
      xp4[4*k +: 4] = ({1'b0, idx4} < 5'(NNIB)) ? 4'(a >> {idx4, 2'b00}) : 4'h0;
    end

    pk         = {b[XLEN/2-1:0], a[XLEN/2-1:0]};
    pkh        = '0;
    pkh[15:0]  = {b[7:0], a[7:0]};

    return ({XLEN{sel[OP_ROL]}}    & rol)   |
           ({XLEN{sel[OP_ROR]}}    & ror)   |
           ({XLEN{sel[OP_BREV8]}}  & brev)  |
           ({XLEN{sel[OP_REV8]}}   & rev)   |
           ({XLEN{sel[OP_ZIP]}}    & zip)   |
           ({XLEN{sel[OP_UNZIP]}}  & unzip) |
           ({XLEN{sel[OP_XPERM8]}} & xp8)   |
           ({XLEN{sel[OP_XPERM4]}} & xp4)   |
           ({XLEN{sel[OP_PACK]}}   & pk)    |
           ({XLEN{sel[OP_PACKH]}}  & pkh);
  endfunction

  logic             inReady;
  logic             accept;
  logic             outValid;
  logic [XLEN-1:0]  outResult;
  logic [TAG_W-1:0] outTag;
  logic             outIllegal;

  // A flush masks the accept but leaves in_ready_o itself untouched.
  assign accept = bus.in_valid_i && inReady && !flush_i;

  if (STAGES == 2) begin : gTwoStage
    logic             s1Valid_q, s1Valid_d;
    logic [3:0]       s1Op_q;
    logic [NOPS-1:0]  s1Sel_q;
    logic [XLEN-1:0]  s1Rs1_q;
    logic [XLEN-1:0]  s1Rs2_q;
    logic [TAG_W-1:0] s1Tag_q;
    logic             s2Valid_q, s2Valid_d;
    logic [XLEN-1:0]  s2Result_q;
    logic [TAG_W-1:0] s2Tag_q;
    logic             s2Illegal_q;
    logic             fullPipe;
    logic             s2Load;
    logic             s1Load;

    // Stage advance: a stage loads when it is empty or its content moves on.
    always_comb begin
      fullPipe  = s1Valid_q && s2Valid_q;
      s2Load    = !s2Valid_q || bus.out_ready_i;
      s1Load    = !s1Valid_q || s2Load;
      inReady   = !fullPipe || bus.out_ready_i;
      s1Valid_d = s1Valid_q;
      s2Valid_d = s2Valid_q;
      if (flush_i) begin
        s1Valid_d = 1'b0;
        s2Valid_d = 1'b0;
      end else begin
        if (s1Load) s1Valid_d = accept;
        if (s2Load) s2Valid_d = s1Valid_q;
      end
    end

    // Valid bits are the only reset state in the pipeline.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s1Valid_q <= 1'b0;
        s2Valid_q <= 1'b0;
      end else begin
        s1Valid_q <= s1Valid_d;
        s2Valid_q <= s2Valid_d;
      end
    end

    // S1 captures operands, tag and the decoded select on accept.
    always_ff @(posedge clk) begin
      if (accept) begin
        s1Op_q  <= bus.op_i;
        s1Sel_q <= decodeOp(bus.op_i);
        s1Rs1_q <= bus.rs1_i;
        s1Rs2_q <= bus.rs2_i;
        s1Tag_q <= bus.tag_i;
      end
    end

    // S2 computes and captures the result whenever S1 moves forward.
    always_ff @(posedge clk) begin
      if (s2Load && s1Valid_q) begin
        s2Result_q  <= computeOp(s1Sel_q, s1Rs1_q, s1Rs2_q);
        s2Tag_q     <= s1Tag_q;
        s2Illegal_q <= isIllegal(s1Op_q);
      end
    end

    assign outValid   = s2Valid_q;
    assign outResult  = s2Result_q;
    assign outTag     = s2Tag_q;
    assign outIllegal = s2Illegal_q;
  end else begin : gOneStage
    logic             sValid_q, sValid_d;
    logic [XLEN-1:0]  sResult_q;
    logic [TAG_W-1:0] sTag_q;
    logic             sIllegal_q;
    logic             sLoad;

    // Single stage: it is the whole pipe, so it is full whenever valid.
    always_comb begin
      sLoad    = !sValid_q || bus.out_ready_i;
      inReady  = sLoad;
      sValid_d = sValid_q;
      if (flush_i) begin
        sValid_d = 1'b0;
      end else if (sLoad) begin
        sValid_d = accept;
      end
    end

    // Valid bit register with synchronous reset.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sValid_q <= 1'b0;
      end else begin
        sValid_q <= sValid_d;
      end
    end

    // Decode, compute and capture in the accept cycle.
    always_ff @(posedge clk) begin
      if (accept) begin
        sResult_q  <= computeOp(decodeOp(bus.op_i), bus.rs1_i, bus.rs2_i);
        sTag_q     <= bus.tag_i;
        sIllegal_q <= isIllegal(bus.op_i);
      end
    end

    assign outValid   = sValid_q;
    assign outResult  = sResult_q;
    assign outTag     = sTag_q;
    assign outIllegal = sIllegal_q;
  end

  assign bus.in_ready_o  = inReady;
  assign bus.out_valid_o = outValid;
  assign bus.result_o    = outValid ? outResult : '0;
  assign bus.tag_o       = outValid ? outTag : '0;
  assign bus.illegal_o   = outValid && outIllegal;

endmodule
